// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the five-stage pipeline controller: stage indices and FSM states.
// Used by pipe_ctrl (optional PIPE_PERF_CNT_EN counters live in the top).
package pipe_ctrl_pkg;

    localparam int NSTAGE  = 5;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard detector: a load in EXE feeding a source register of the instruction in ID.
// Purely combinational; unaffected by the PIPE_PERF_CNT_EN build option.
module pipe_hazard_det (
    input  logic       id_valid,
    input  logic       ex_valid,
    input  logic       ex_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard = id_valid & ex_valid & ex_load & (ex_rd != 5'd0)
                  & ((ex_rd == id_rs) | (ex_rd == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline handshake controller with load-use stall and exception flush/redirect.
// Define PIPE_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counter ports.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSTAGE-1:0] stage_over,
    input  logic              exc_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              ex_load,
    input  logic [4:0]        ex_rd,
    output logic [NSTAGE-1:0] allow_in,
    output logic [NSTAGE-1:0] stage_valid,
    output logic              cancel,
    output logic              pc_redirect
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    state_t            state_reg;
    state_t            state_next;
    logic              hazard;
    logic              exc_take;
    logic [NSTAGE-1:0] eff_over;
    logic [NSTAGE-1:0] allow_run;
    logic [NSTAGE-1:0] valid_next;

    pipe_hazard_det u_hazard (
        .id_valid (stage_valid[STG_ID]),
        .ex_valid (stage_valid[STG_EXE]),
        .ex_load  (ex_load),
        .ex_rd    (ex_rd),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .hazard   (hazard)
    );

    always_comb begin
        eff_over         = stage_over;
        eff_over[STG_ID] = stage_over[STG_ID] & ~hazard;
    end

    // Back-pressure ripples from WB towards IF: a stage may accept only if it is empty
    // or its current occupant can move on.
    always_comb begin
        allow_run             = '0;
        allow_run[NSTAGE-1]   = ~stage_valid[NSTAGE-1] | stage_over[NSTAGE-1];
        for (int i = NSTAGE - 2; i >= 0; i--) begin
            allow_run[i] = ~stage_valid[i] | (eff_over[i] & allow_run[i+1]);
        end
    end

    always_comb begin
        state_next  = state_reg;
        allow_in    = '0;
        cancel      = 1'b0;
        pc_redirect = 1'b0;
        exc_take    = 1'b0;
        unique case (state_reg)
            ST_RUN: begin
                allow_in = allow_run;
                exc_take = exc_valid & stage_valid[STG_WB];
                if (exc_take) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                cancel     = 1'b1;
                state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                pc_redirect = 1'b1;
                state_next  = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    genvar gi;
    generate
        for (gi = 1; gi < NSTAGE; gi++) begin : g_stage
            // An EXE bubble during a stall falls out naturally: eff_over[ID] is low.
            assign valid_next[gi] = cancel        ? 1'b0 :
                                    allow_in[gi]  ? (stage_valid[gi-1] & eff_over[gi-1]) :
                                                    stage_valid[gi];
        end
    endgenerate

    assign valid_next[STG_IF] = cancel                            ? 1'b0 :
                                (allow_in[STG_IF] | pc_redirect)  ? 1'b1 :
                                                                    stage_valid[STG_IF];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_RUN;
            stage_valid <= '0;
        end else begin
            state_reg   <= state_next;
            stage_valid <= valid_next;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // A stall cycle that coincides with an accepted exception is not counted as a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state_reg == ST_RUN) && hazard && !exc_take) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (exc_take) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized traffic against a reference model.
// Counter checks are compiled in when PIPE_PERF_CNT_EN is defined.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] stage_over;
    logic       exc_valid;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       ex_load;
    logic [4:0] allow_in, stage_valid;
    logic       cancel, pc_redirect;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stage_over  (stage_over),
        .exc_valid   (exc_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_load     (ex_load),
        .ex_rd       (ex_rd),
        .allow_in    (allow_in),
        .stage_valid (stage_valid),
        .cancel      (cancel),
        .pc_redirect (pc_redirect)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: occupancy bits plus a countdown of remaining recovery cycles
    // (2 = flushing, 1 = redirecting, 0 = running normally).
    int          m_recover;
    logic [4:0]  m_occ;
    logic [31:0] m_stall, m_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hazard();
        return m_occ[1] && m_occ[2] && ex_load && (ex_rd != 5'd0)
               && ((ex_rd == id_rs) || (ex_rd == id_rt));
    endfunction

    function automatic logic [4:0] model_done();
        logic [4:0] d;
        d = stage_over;
        if (model_hazard()) d[1] = 1'b0;
        return d;
    endfunction

    function automatic logic [4:0] model_allow();
        logic [4:0] a, d;
        a = '0;
        if (m_recover != 0) return a;
        d = model_done();
        a[4] = !m_occ[4] || stage_over[4];
        for (int i = 3; i >= 0; i--) a[i] = !m_occ[i] || (d[i] && a[i+1]);
        return a;
    endfunction

    task automatic set_in(input logic [4:0] so, input logic exc, input logic ld,
                          input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        stage_over = so; exc_valid = exc; ex_load = ld;
        ex_rd = rd; id_rs = rs; id_rt = rt;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        m_recover = 0; m_occ = '0; m_stall = '0; m_flush = '0;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One clock: compare everything mid-cycle, advance the model, land 1 time unit after the edge.
    task automatic step();
        logic [4:0] a, d, nxt;
        logic       haz;
        @(negedge clk);
        haz = model_hazard();
        a   = model_allow();
        d   = model_done();
        check("allow_in",    32'(allow_in),    32'(a));
        check("stage_valid", 32'(stage_valid), 32'(m_occ));
        check("cancel",      32'(cancel),      32'(m_recover == 2));
        check("pc_redirect", 32'(pc_redirect), 32'(m_recover == 1));
`ifdef PIPE_PERF_CNT_EN
        check("stall_cnt",   stall_cnt,        m_stall);
        check("flush_cnt",   flush_cnt,        m_flush);
`endif
        nxt = m_occ;
        if (m_recover == 2) begin
            nxt = '0;
            m_recover = 1;
        end else if (m_recover == 1) begin
            nxt = 5'b00001;
            m_recover = 0;
        end else begin
            if (a[0]) nxt[0] = 1'b1;
            for (int i = 1; i < 5; i++) if (a[i]) nxt[i] = m_occ[i-1] && d[i-1];
            if (exc_valid && m_occ[4]) begin
                m_recover = 2;
                m_flush++;
            end else if (haz) begin
                m_stall++;
            end
        end
        @(posedge clk);
        #1;
        m_occ = nxt;
    endtask

    initial begin
        logic [31:0] saved;
        set_in(5'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        do_reset(3);
        check("rst_allow",   32'(allow_in),    32'h1f);
        check("rst_valid",   32'(stage_valid), 32'h00);
        check("rst_cancel",  32'(cancel),      32'h0);
        check("rst_redir",   32'(pc_redirect), 32'h0);

        // Fill: five cycles with every stage finishing.
        set_in(5'h1f, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (5) begin
            step();
            check("fill_allow", 32'(allow_in), 32'h1f);
        end
        check("fill_valid", 32'(stage_valid), 32'h1f);

        // Load-use stall on rs.
        set_in(5'h1f, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9);
        #1 check("haz_allow", 32'(allow_in), 32'h1c);
        saved = m_stall;
        step();
        check("haz_bubble", 32'(stage_valid), 32'h1b);
        check("haz_count_model", m_stall, saved + 32'd1);
`ifdef PIPE_PERF_CNT_EN
        check("haz_stall_cnt", stall_cnt, saved + 32'd1);
`endif

        // Load into r0 is never a dependency.
        set_in(5'h1f, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        #1 check("r0_allow", 32'(allow_in), 32'h1f);
        step();

        // Exception with WB valid; exc_valid held high through FLUSH must be ignored.
        set_in(5'h1f, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        check("exc_cancel", 32'(cancel),   32'h1);
        check("exc_allow",  32'(allow_in), 32'h0);
        step();
        check("exc_redirect", 32'(pc_redirect), 32'h1);
        check("exc_cancel_off", 32'(cancel),    32'h0);
        check("exc_flushed", 32'(stage_valid),  32'h0);
`ifdef PIPE_PERF_CNT_EN
        check("exc_flush_cnt", flush_cnt, 32'd1);
`endif
        exc_valid = 1'b0;
        step();
        check("redir_off", 32'(pc_redirect), 32'h0);
        check("restart",   32'(stage_valid), 32'h01);

        // Exception and hazard together: flush wins, stall not counted.
        set_in(5'h1f, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (5) step();
        set_in(5'h1f, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7);
        saved = m_stall;
        step();
        check("exchaz_cancel", 32'(cancel), 32'h1);
`ifdef PIPE_PERF_CNT_EN
        check("exchaz_stall", stall_cnt, saved);
`endif
        set_in(5'h1f, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (3) step();

        // Reset in the middle of FLUSH aborts the redirect.
        repeat (5) step();
        exc_valid = 1'b1;
        step();
        check("pre_rst_cancel", 32'(cancel), 32'h1);
        exc_valid = 1'b0;
        do_reset(2);
        check("post_rst_cancel", 32'(cancel), 32'h0);
        repeat (4) begin
            step();
            check("no_redirect", 32'(pc_redirect), 32'h0);
        end

        // Randomized traffic with small register numbers to provoke dependencies.
        repeat (400) begin
            logic [4:0] so;
            for (int i = 0; i < 5; i++) so[i] = ($urandom_range(0, 3) != 0);
            set_in(so, ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            if ($urandom_range(0, 199) == 0) do_reset(1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
